// File: rtl/add_pkg.sv
// Shared types and default sizes for the adder capture stage.
package add_pkg;

    localparam int ADD_DATA_WIDTH = 4;
    localparam int ADD_CNT_WIDTH  = 8;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} cap_state_t;

endpackage

// File: rtl/add_capture_if.sv
// Handshake bundle between the adder, the capture stage and its consumer.
interface add_capture_if
    import add_pkg::*;
#(
    parameter int DATA_WIDTH = ADD_DATA_WIDTH
);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH:0]   in_result;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_sum;
    logic                  out_carry;
    logic                  out_zero;

    modport master (
        output in_valid, in_result, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_zero
    );

    modport slave (
        input  in_valid, in_result, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_zero
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with enable; holds at all-ones, cleared by reset.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] ONE_V = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && !(&count_q)) begin
            count_d = count_q + ONE_V;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/add_capture.sv
// Adder result capture: two-entry skid FIFO splitting sum/carry/zero.
// Define ADD_CAPTURE_STATS_EN to add the saturating carry_count port.
module add_capture
    import add_pkg::*;
#(
    parameter int DATA_WIDTH = ADD_DATA_WIDTH
`ifdef ADD_CAPTURE_STATS_EN
  , parameter int CNT_WIDTH  = ADD_CNT_WIDTH
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    add_capture_if.slave         bus
`ifdef ADD_CAPTURE_STATS_EN
  , output logic [CNT_WIDTH-1:0] carry_count
`endif
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] sum;
        logic                  carry;
        logic                  zero;
    } entry_t;

    cap_state_t state_q;
    cap_state_t state_d;
    entry_t     head_q;
    entry_t     head_d;
    entry_t     tail_q;
    entry_t     tail_d;
    entry_t     new_e;
    logic       push;
    logic       pop;

    // in_ready comes from registered state only, so out_ready never
    // reaches the upstream stage combinationally.
    assign bus.in_ready  = (state_q != TWO);
    assign bus.out_valid = (state_q != EMPTY);

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_comb begin
        new_e.sum   = bus.in_result[DATA_WIDTH-1:0];
        new_e.carry = bus.in_result[DATA_WIDTH];
        new_e.zero  = ~|bus.in_result[DATA_WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = new_e;
                    state_d = ONE;
                end
            end
            ONE: begin
                case ({push, pop})
                    2'b10: begin
                        tail_d  = new_e;
                        state_d = TWO;
                    end
                    2'b01: state_d = EMPTY;
                    2'b11: head_d = new_e;
                    default: ;
                endcase
            end
            TWO: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign bus.out_sum   = head_q.sum;
    assign bus.out_carry = head_q.carry;
    assign bus.out_zero  = head_q.zero;

`ifdef ADD_CAPTURE_STATS_EN
    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_carry_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (push && bus.in_result[DATA_WIDTH]),
        .count_o (carry_count)
    );
`endif

endmodule

// File: tb/tb_add_capture.sv
// Self-checking bench for add_capture: directed scenarios plus a
// randomized run against a two-slot FIFO queue model.
module tb_add_capture;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    add_capture_if #(.DATA_WIDTH(4)) bus ();

`ifdef ADD_CAPTURE_STATS_EN
    logic [7:0] carry_count;
`endif

    add_capture dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus)
`ifdef ADD_CAPTURE_STATS_EN
      , .carry_count (carry_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_result = '0;
        #3;
        checks += 5;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        end
        if (bus.out_sum !== 4'h0) begin
            errors++;
            $display("FAIL reset_out_sum got=%h exp=0", bus.out_sum);
        end
        if (bus.out_carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_carry got=%b exp=0", bus.out_carry);
        end
        if (bus.out_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_zero got=%b exp=0", bus.out_zero);
        end
`ifdef ADD_CAPTURE_STATS_EN
        checks++;
        if (carry_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_carry_count got=%0d exp=0", carry_count);
        end
`endif
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single_pass();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_result = 5'b01101;
        tick();
        bus.in_valid = 1'b0;
        checks += 4;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_valid got=%b exp=1", bus.out_valid);
        end
        if (bus.out_sum !== 4'hD) begin
            errors++;
            $display("FAIL single_sum got=%h exp=d", bus.out_sum);
        end
        if (bus.out_carry !== 1'b0) begin
            errors++;
            $display("FAIL single_carry got=%b exp=0", bus.out_carry);
        end
        if (bus.out_zero !== 1'b0) begin
            errors++;
            $display("FAIL single_zero got=%b exp=0", bus.out_zero);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_result = 5'b10011;
        tick();
        bus.in_result = 5'b00000;
        tick();
        bus.in_valid = 1'b0;
        checks += 4;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full_ready got=%b exp=0", bus.in_ready);
        end
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_valid got=%b exp=1", bus.out_valid);
        end
        if (bus.out_sum !== 4'h3) begin
            errors++;
            $display("FAIL bp_head_sum got=%h exp=3", bus.out_sum);
        end
        if (bus.out_carry !== 1'b1) begin
            errors++;
            $display("FAIL bp_head_carry got=%b exp=1", bus.out_carry);
        end
        bus.in_valid  = 1'b1;
        bus.in_result = 5'b00111;
        tick();
        checks += 3;
        if (bus.out_sum !== 4'h3 || bus.out_carry !== 1'b1) begin
            errors++;
            $display("FAIL bp_stable got=%h/%b exp=3/1",
                     bus.out_sum, bus.out_carry);
        end
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_still_full got=%b exp=0", bus.in_ready);
        end
        if (bus.out_zero !== 1'b0) begin
            errors++;
            $display("FAIL bp_head_zero got=%b exp=0", bus.out_zero);
        end
        // Full with out_ready high: the offered item must be dropped.
        bus.in_result = 5'b01111;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks += 4;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_second_valid got=%b exp=1", bus.out_valid);
        end
        if (bus.out_sum !== 4'h0) begin
            errors++;
            $display("FAIL bp_second_sum got=%h exp=0", bus.out_sum);
        end
        if (bus.out_zero !== 1'b1 || bus.out_carry !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_flags got=z%b/c%b exp=z1/c0",
                     bus.out_zero, bus.out_carry);
        end
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_back got=%b exp=1", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_ignored_push got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_result = 5'(i);
            tick();
            checks++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 ||
                bus.out_sum !== 4'(i)) begin
                errors++;
                $display("FAIL stream_%0d got=r%b/v%b/%h exp=r1/v1/%h",
                         i, bus.in_ready, bus.out_valid, bus.out_sum, 4'(i));
            end
        end
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_drain got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_result = 5'b00101;
        tick();
        bus.in_result = 5'b00110;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_full got=%b exp=0", bus.in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_async_valid got=%b exp=0", bus.out_valid);
        end
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_async_ready got=%b exp=1", bus.in_ready);
        end
        tick();
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_result = 5'b11111;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== 4'hF ||
            bus.out_carry !== 1'b1 || bus.out_zero !== 1'b0) begin
            errors++;
            $display("FAIL mid_after got=v%b/%h/c%b/z%b exp=v1/f/c1/z0",
                     bus.out_valid, bus.out_sum, bus.out_carry, bus.out_zero);
        end
        tick();
    endtask

    task automatic test_random();
        logic [4:0] q[$];
        logic [4:0] r;
        logic       v;
        logic       rd;
        logic       do_push;
        logic       do_pop;
        int         cnt;
        cnt = 0;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            v  = 1'($urandom_range(0, 1));
            rd = ($urandom_range(0, 9) < 6);
            r  = 5'($urandom_range(0, 31));
            bus.in_valid  = v;
            bus.out_ready = rd;
            bus.in_result = v ? r : 5'bx;
            do_push = v && (q.size() < 2);
            do_pop  = rd && (q.size() > 0);
            tick();
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(r);
            if (do_push && r[4] && cnt < 255) cnt++;
            checks++;
            if (bus.out_valid !== (q.size() != 0) ||
                bus.in_ready !== (q.size() < 2)) begin
                errors++;
                $display("FAIL rand_%0d_hs got=v%b/r%b exp_depth=%0d",
                         n, bus.out_valid, bus.in_ready, q.size());
            end else if (q.size() != 0) begin
                checks++;
                if (bus.out_sum !== q[0][3:0] || bus.out_carry !== q[0][4] ||
                    bus.out_zero !== (q[0][3:0] == 4'h0)) begin
                    errors++;
                    $display("FAIL rand_%0d_head got=%h/c%b/z%b exp=%h/c%b/z%b",
                             n, bus.out_sum, bus.out_carry, bus.out_zero,
                             q[0][3:0], q[0][4], q[0][3:0] == 4'h0);
                end
            end
`ifdef ADD_CAPTURE_STATS_EN
            checks++;
            if (carry_count !== 8'(cnt)) begin
                errors++;
                $display("FAIL rand_%0d_cnt got=%0d exp=%0d",
                         n, carry_count, cnt);
            end
`endif
        end
        bus.in_valid = 1'b0;
    endtask

`ifdef ADD_CAPTURE_STATS_EN
    task automatic test_stats();
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_result = 5'b10000;
        for (int i = 0; i < 10; i++) tick();
        bus.in_result = 5'b00011;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (carry_count !== 8'd10) begin
            errors++;
            $display("FAIL stats_partial got=%0d exp=10", carry_count);
        end
        bus.in_result = 5'b10000;
        for (int i = 0; i < 290; i++) tick();
        checks++;
        if (carry_count !== 8'd255) begin
            errors++;
            $display("FAIL stats_saturate got=%0d exp=255", carry_count);
        end
        bus.in_result = 5'b00000;
        for (int i = 0; i < 4; i++) tick();
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (carry_count !== 8'd255) begin
            errors++;
            $display("FAIL stats_hold got=%0d exp=255", carry_count);
        end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single_pass();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef ADD_CAPTURE_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
